// File: rtl/spart_tx.sv
// SPART transmitter: a one-deep holding buffer feeds a start/data/stop serialiser paced by tx_enable.
// Optional macro SPART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module spart_tx #(
   parameter int DATA_BITS     = 8,
   parameter int TICKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_enable,
   input  logic                 write,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tbr,
   output logic                 txd
);

   localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

`ifdef SPART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t               state, state_n;
   logic [DATA_BITS-1:0] buf_data;
   logic                 buf_full;
   logic                 load;
   logic [DATA_BITS-1:0] shifter, shifter_n;
   logic [TW-1:0]        tick_cnt, tick_n;
   logic [BW-1:0]        bit_cnt, bit_n;
   logic                 txd_q, txd_n;
   logic                 tick_end;

   // A write is only taken while the buffer is empty; the serialiser empties it when it loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_data <= '0;
         buf_full <= 1'b0;
      end else if (write && !buf_full) begin
         buf_data <= tx_data;
         buf_full <= 1'b1;
      end else if (load) begin
         buf_full <= 1'b0;
      end
   end

`ifdef SPART_TX_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else if (load) begin
         parity_q <= ^buf_data;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         shifter  <= '0;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         txd_q    <= 1'b1;
      end else begin
         state    <= state_n;
         shifter  <= shifter_n;
         tick_cnt <= tick_n;
         bit_cnt  <= bit_n;
         txd_q    <= txd_n;
      end
   end

   assign tick_end = (state != IDLE) && tx_enable && (tick_cnt == TICK_LAST);

   // txd_n is the value the line takes next cycle, so every transition lands one clock after its tick.
   always_comb begin
      state_n   = state;
      shifter_n = shifter;
      tick_n    = tick_cnt;
      bit_n     = bit_cnt;
      txd_n     = txd_q;
      load      = 1'b0;

      if (state != IDLE && tx_enable) begin
         tick_n = tick_end ? '0 : tick_cnt + TW'(1);
      end

      case (state)
         IDLE: begin
            txd_n = 1'b1;
            if (buf_full && tx_enable) begin
               load      = 1'b1;
               shifter_n = buf_data;
               tick_n    = '0;
               bit_n     = '0;
               state_n   = START;
               txd_n     = 1'b0;
            end
         end
         START: begin
            if (tick_end) begin
               state_n = DATA;
               txd_n   = shifter[0];
            end
         end
         DATA: begin
            if (tick_end) begin
               shifter_n = shifter >> 1;
               if (bit_cnt == BIT_LAST) begin
                  bit_n = '0;
`ifdef SPART_TX_PARITY_EN
                  state_n = PARITY;
                  txd_n   = parity_q;
`else
                  state_n = STOP;
                  txd_n   = 1'b1;
`endif
               end else begin
                  bit_n = bit_cnt + BW'(1);
                  txd_n = shifter_n[0];
               end
            end
         end
`ifdef SPART_TX_PARITY_EN
         PARITY: begin
            if (tick_end) begin
               state_n = STOP;
               txd_n   = 1'b1;
            end
         end
`endif
         STOP: begin
            // A byte already waiting starts straight away, with no idle bit between frames.
            if (tick_end) begin
               if (buf_full) begin
                  load      = 1'b1;
                  shifter_n = buf_data;
                  bit_n     = '0;
                  state_n   = START;
                  txd_n     = 1'b0;
               end else begin
                  state_n = IDLE;
                  txd_n   = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            txd_n   = 1'b1;
         end
      endcase
   end

   assign tbr = ~buf_full;
   assign txd = txd_q;

endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx: a frame table, hand-written timing and corner sequences, and a randomized run,
// all watched every cycle by a frame-level model of the serial line and holding buffer.
module tb_spart_tx;

   localparam int DATA_BITS = 8;
   localparam int TPB       = 16;
`ifdef SPART_TX_PARITY_EN
   localparam int FRAME_LEN = DATA_BITS + 3;
`else
   localparam int FRAME_LEN = DATA_BITS + 2;
`endif

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       tx_enable = 1'b0;
   logic       write     = 1'b0;
   logic [7:0] tx_data   = 8'h00;
   logic       tbr;
   logic       txd;

   int errors = 0;
   int checks = 0;

   int tick_period = 40;
   int tick_div    = 0;
   bit tick_random = 1'b0;
   bit mon_en      = 1'b0;

   spart_tx #(.DATA_BITS(DATA_BITS), .TICKS_PER_BIT(TPB)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_enable(tx_enable),
      .write    (write),
      .tx_data  (tx_data),
      .tbr      (tbr),
      .txd      (txd)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tick_random) begin
         tx_enable = !tx_enable && ($urandom_range(0, 2) == 0);
      end else begin
         tx_enable = (tick_div == tick_period - 1);
         tick_div  = (tick_div >= tick_period - 1) ? 0 : tick_div + 1;
      end
   end

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Transmitted bit i of a frame sits at index i: start, data LSB first, optional parity, stop.
   function automatic logic [10:0] make_frame(input logic [7:0] d);
      logic [10:0] f;
      f = '0;
      for (int i = 0; i < DATA_BITS; i++) f[i+1] = d[i];
`ifdef SPART_TX_PARITY_EN
      f[DATA_BITS+1] = ^d;
      f[DATA_BITS+2] = 1'b1;
`else
      f[DATA_BITS+1] = 1'b1;
`endif
      return f;
   endfunction

   logic       s_rst = 1'b1;
   logic       s_write = 1'b0;
   logic       s_tick = 1'b0;
   logic [7:0] s_data = 8'h00;

   always @(posedge clk) begin
      s_rst   <= rst;
      s_write <= write;
      s_tick  <= tx_enable;
      s_data  <= tx_data;
   end

   // Line model: a frame starts on a tick once a byte is waiting and the line is free, and bit k
   // of the frame is on the line while k*TPB <= ticks since start < (k+1)*TPB.
   logic        m_full   = 1'b0;
   logic [7:0]  m_byte   = 8'h00;
   bit          m_active = 1'b0;
   int          m_ticks  = 0;
   logic [10:0] m_frame  = '1;
   bit          w_ok;
   logic        exp_line;

   always @(negedge clk) begin
      if (s_rst) begin
         m_full   = 1'b0;
         m_active = 1'b0;
         m_ticks  = 0;
      end else begin
         w_ok = s_write && !m_full;
         if (m_active && s_tick) begin
            m_ticks++;
            if (m_ticks == FRAME_LEN * TPB) m_active = 1'b0;
         end
         if (!m_active && m_full && s_tick) begin
            m_frame  = make_frame(m_byte);
            m_active = 1'b1;
            m_ticks  = 0;
            m_full   = 1'b0;
         end
         if (w_ok) begin
            m_full = 1'b1;
            m_byte = s_data;
         end
      end
      if (mon_en) begin
         exp_line = m_active ? m_frame[m_ticks / TPB] : 1'b1;
         check_output("model_txd", {31'b0, txd}, {31'b0, exp_line});
         check_output("model_tbr", {31'b0, tbr}, {31'b0, !m_full});
      end
   end

   task automatic apply_stimulus(input logic [7:0] d);
      write   = 1'b1;
      tx_data = d;
      @(negedge clk);
      write   = 1'b0;
   endtask

   task automatic wait_low(input string name, input int limit);
      int n;
      n = 0;
      while (txd !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (txd !== 1'b0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: no start bit within %0d cycles, txd=%b", name, limit, txd);
      end
   endtask

   task automatic measure_run(input logic lvl, input int limit, output int len);
      len = 0;
      while (txd === lvl && len < limit) begin
         @(negedge clk);
         len++;
      end
   endtask

   bit exp_bits[$];

   task automatic push_frame(input logic [7:0] d);
      logic [10:0] f;
      f = make_frame(d);
      for (int i = 0; i < FRAME_LEN; i++) exp_bits.push_back(f[i]);
   endtask

   // Walks exp_bits as runs of equal level; the last run must also hold for 'hold' idle cycles.
   task automatic run_check(input string name, input int hold);
      int  bitclk, i, n, len;
      bit  lvl;
      bitclk = TPB * tick_period;
      i = 0;
      while (i < exp_bits.size()) begin
         lvl = exp_bits[i];
         n = 0;
         while (i < exp_bits.size() && exp_bits[i] == lvl) begin
            n++;
            i++;
         end
         if (i < exp_bits.size()) begin
            measure_run(lvl, (n + 2) * bitclk, len);
            check_output(name, len, n * bitclk);
         end else begin
            measure_run(lvl, n * bitclk + hold, len);
            check_output({name, "_tail"}, len, n * bitclk + hold);
         end
      end
   endtask

   typedef struct packed {
      logic [7:0]  data;
      logic [10:0] frame;
   } vec_t;

   vec_t vecs[8];

   initial begin : watchdog
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int          len, bitclk;
      logic [10:0] got;

`ifdef SPART_TX_PARITY_EN
      vecs[0] = '{data: 8'h88, frame: 11'h510};
      vecs[1] = '{data: 8'h00, frame: 11'h400};
      vecs[2] = '{data: 8'hFF, frame: 11'h5FE};
      vecs[3] = '{data: 8'h5A, frame: 11'h4B4};
      vecs[4] = '{data: 8'h07, frame: 11'h60E};
      vecs[5] = '{data: 8'h03, frame: 11'h406};
      vecs[6] = '{data: 8'h01, frame: 11'h602};
      vecs[7] = '{data: 8'hA3, frame: 11'h546};
`else
      vecs[0] = '{data: 8'h88, frame: 11'h310};
      vecs[1] = '{data: 8'h00, frame: 11'h200};
      vecs[2] = '{data: 8'hFF, frame: 11'h3FE};
      vecs[3] = '{data: 8'h5A, frame: 11'h2B4};
      vecs[4] = '{data: 8'h07, frame: 11'h20E};
      vecs[5] = '{data: 8'h03, frame: 11'h206};
      vecs[6] = '{data: 8'h01, frame: 11'h202};
      vecs[7] = '{data: 8'hA3, frame: 11'h346};
`endif

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_output("reset_txd", {31'b0, txd}, 32'd1);
      check_output("reset_tbr", {31'b0, tbr}, 32'd1);
      mon_en = 1'b1;
      repeat (50) @(negedge clk);

      $display("[TB] single frame 0x88, 40-clk ticks");
      apply_stimulus(8'h88);
      check_output("tbr_after_write", {31'b0, tbr}, 32'd0);
      wait_low("start_88", 2 * tick_period + 4);
      check_output("tbr_at_start_88", {31'b0, tbr}, 32'd1);
      exp_bits.delete();
      push_frame(8'h88);
      run_check("runs_88", 2 * TPB * tick_period);

      $display("[TB] back-to-back 0x55 then 0xA3");
      exp_bits.delete();
      push_frame(8'h55);
      push_frame(8'hA3);
      apply_stimulus(8'h55);
      wait_low("start_55", 2 * tick_period + 4);
      fork
         run_check("runs_b2b", TPB * tick_period);
         begin
            repeat (3 * TPB * tick_period) @(negedge clk);
            apply_stimulus(8'hA3);
            check_output("tbr_after_a3_write", {31'b0, tbr}, 32'd0);
         end
      join

      tick_period = 4;
      bitclk = TPB * tick_period;
      repeat (20) @(negedge clk);

      $display("[TB] write while buffer full is ignored");
      apply_stimulus(8'h11);
      apply_stimulus(8'h22);
      wait_low("start_11", 2 * tick_period + 4);
      exp_bits.delete();
      push_frame(8'h11);
      run_check("runs_11_only", 2 * FRAME_LEN * bitclk);

      $display("[TB] reset in the middle of 0xF0");
      apply_stimulus(8'hF0);
      wait_low("start_f0", 2 * tick_period + 4);
      repeat (4 * bitclk + bitclk / 2) @(negedge clk);
      check_output("pre_reset_txd", {31'b0, txd}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("post_reset_txd", {31'b0, txd}, 32'd1);
      check_output("post_reset_tbr", {31'b0, tbr}, 32'd1);
      measure_run(1'b1, 3 * FRAME_LEN * bitclk, len);
      check_output("quiet_after_reset", len, 3 * FRAME_LEN * bitclk);

      $display("[TB] frame table");
      for (int k = 0; k < 8; k++) begin
         apply_stimulus(vecs[k].data);
         wait_low("start_vec", 2 * tick_period + 4);
         got = '0;
         repeat (bitclk / 2) @(negedge clk);
         for (int i = 0; i < FRAME_LEN; i++) begin
            got[i] = txd;
            repeat (bitclk) @(negedge clk);
         end
         check_output("vec_frame", {21'b0, got}, {21'b0, vecs[k].frame});
      end

      $display("[TB] randomized writes, ticks and resets");
      tick_random = 1'b1;
      for (int r = 0; r < 40; r++) begin
         repeat ($urandom_range(0, 400)) @(negedge clk);
         if ($urandom_range(0, 19) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else begin
            apply_stimulus(8'($urandom));
            if ($urandom_range(0, 3) == 0) apply_stimulus(8'($urandom));
         end
      end
      tick_random = 1'b0;
      repeat (3 * FRAME_LEN * bitclk) @(negedge clk);
      check_output("drained_txd", {31'b0, txd}, 32'd1);
      check_output("drained_tbr", {31'b0, tbr}, 32'd1);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spart_tx.md
Name: spart_tx

Overview:
- Transmit half of the SPART serial port; the counterpart of the receive block.
- Accepts a byte from the bus interface into a one-deep holding buffer.
- Serialises the byte as an async frame on txd: start bit 0, data LSB first, stop bit 1.
- Bit timing comes from the shared baud generator's tx_enable pulse, which runs at 16x the baud rate. This matches the receiver's oversample enable.

Parameters:
- DATA_BITS, 8, data bits per frame.
- TICKS_PER_BIT, 16, tx_enable pulses per serial bit time.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_enable  input  1  single-cycle baud tick from the baud generator, 16x baud.
- write  input  1  bus strobe; loads tx_data into the holding buffer when tbr=1.
- tx_data  input  DATA_BITS  byte to transmit.
- tbr  output  1  transmit buffer ready; 1 = holding buffer empty.
- txd  output  1  serial output line; idle high.

Behaviour:
- Reset:
  - tbr=1, txd=1, state IDLE.
  - Holding buffer, shift register, tick counter and bit counter all cleared.
  - Reset asserted mid-frame aborts the frame; txd=1 on the following cycle.
- Holding buffer:
  - write with tbr=1: capture tx_data; tbr=0 from the next cycle.
  - write with tbr=0: ignored; buffer contents unchanged, no error flag.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - txd=1.
  - When buffer is full and tx_enable=1: load shifter from buffer, mark buffer empty, enter START.
  - On the next cycle: txd=0 and tbr=1.
  - Frame start is therefore aligned to a baud tick.
- Tick counter:
  - Increments on each tx_enable pulse while not in IDLE.
  - The bit period ends on the TICKS_PER_BIT-th pulse; the counter then wraps to 0 and the next bit is driven the following cycle.
  - Each bit lasts exactly TICKS_PER_BIT tick periods. With a 40-clk tick period, that is 640 clk per bit.
- START → DATA after one bit period. txd = shifter[0].
- DATA:
  - At the end of each bit period, shift right and increment the bit counter.
  - After DATA_BITS bits, enter STOP with txd=1.
- STOP ends after one bit period:
  - Buffer full: load shifter, mark buffer empty, enter START directly. No idle gap; tbr rises the same cycle txd falls.
  - Buffer empty: enter IDLE.
- write during any non-IDLE state: accepted if tbr=1 (double buffering). tbr=1 for essentially the whole frame after its start.
- tx_enable pulses in IDLE with an empty buffer have no effect.
- txd is a registered output, glitch-free.

Optional Feature:
- Macro: SPART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting one bit period.
  - txd = XOR of the DATA_BITS transmitted bits (even parity).
  - Frame is 1+DATA_BITS+1+1 bits: 11 bit times at default.
- Undefined:
  - No PARITY state; frame is 10 bit times at default.
  - No parity logic is synthesised.

Test Plan:
- Reset, tx_enable every 40 clk, write=1 for one cycle with tx_data=0x88:
  - tbr falls next cycle.
  - At the next tick, txd=0 for 640 clk, then 0,0,0,1,0,0,0,1 for 640 clk each, then 1.
  - tbr returns to 1 one cycle after the start bit begins.
- Write 0x55, then write 0xA3 while 0x55 is in its DATA phase:
  - 0xA3's start bit begins on the cycle after 0x55's stop bit ends, exactly 640 clk after that stop bit began.
  - tbr stays 0 from the 0xA3 write until 0xA3's start bit.
- Write 0x11 with tbr=1, then write 0x22 while tbr=0 (before the 0x11 frame starts):
  - Only 0x11 is transmitted.
  - txd remains 1 after its stop bit.
- Assert rst for one cycle during bit 3 of a 0xF0 frame:
  - txd=1 and tbr=1 the next cycle.
  - No further edges on txd until a new write.
- Loopback txd into the RX block with matched tx_enable/rx_enable:
  - Send 0x00, 0xFF, 0x5A.
  - RX asserts rda with rx_out equal to each byte in order.
- With SPART_TX_PARITY_EN:
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0.
  - Stop bit appears 640 clk after the parity bit begins.
